binreg_file: RTL and testbench
==============================

# binreg_file

Parametrised, masked, dual-read-port register file for the binary MLP datapath. It holds activation and weight bit-vectors of `DW` bits across `DEPTH` entries, with one write port and two independent registered read ports. A background clear sequencer zeroes the array between layers without a full reset. It generalises the existing 1-bit, 84-entry scratch store.

## Interface
- `DW`, 1: word width in bits, at least 1.
- `DEPTH`, 84: number of entries, at least 2.
- `AW`, 7: address width; must satisfy 2^AW >= DEPTH.

- `clk` input 1: clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous, active-low.
- `wen` input 1: write enable.
- `waddr` input AW: write address.
- `wdata` input DW: write data.
- `wmask` input DW: per-bit write mask; 1 means the bit is written.
- `ren_a` / `ren_b` input 1: read enable for port A / port B.
- `raddr_a` / `raddr_b` input AW: read address for port A / port B.
- `rdata_a` / `rdata_b` output DW: registered read data.
- `rvalid_a` / `rvalid_b` output 1: one-cycle pulse, `rdata_x` updated this cycle.
- `clr_req` input 1: start a background clear.
- `clr_busy` output 1: clear in progress.
- `clr_done` output 1: one-cycle pulse when the clear completes.
- `oob_err` output 1: one-cycle pulse flagging an out-of-range access in the previous cycle.

## Operation
- **Reset (`rst`=0 at an edge):**
  - All entries become 0.
  - `rdata_a`/`rdata_b` become 0.
  - `rvalid_a`/`rvalid_b`, `clr_busy`, `clr_done`, `oob_err` become 0.
  - The clear counter becomes 0 and the FSM goes to IDLE.
  - Reset overrides all other inputs, including during a clear.
- **Write:** a write is accepted when `wen`=1, `waddr`<DEPTH and `clr_busy`=0.
  - Update rule: mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask).
  - `wmask`=0 gives no change.
  - A write with `clr_busy`=1 is dropped silently.
- **Read (per port, independent):** if `ren_x`=1, `rdata_x` <= mem[raddr_x] and `rvalid_x` <= 1.
  - If `ren_x`=0, `rdata_x` holds its value and `rvalid_x` <= 0.
  - Both ports may read the same address in the same cycle.
  - Reads are allowed while a clear is in progress; they return the array contents as they stand before that edge.
- **Out of range:** an address >= DEPTH is out of range.
  - An out-of-range read returns 0 and still pulses `rvalid_x`.
  - An out-of-range write does not change the array.
  - Any out-of-range access with its enable high sets `oob_err` <= 1 for one cycle. This includes a write dropped because of `clr_busy`, if its address is also out of range.
- **Clear FSM:**
  - IDLE: when `clr_req`=1, `clr_busy` <= 1 and cnt <= 0; go to CLEAR.
  - CLEAR, every edge: mem[cnt] <= 0 and cnt <= cnt+1.
  - CLEAR, edge where cnt = DEPTH-1: `clr_busy` <= 0, `clr_done` <= 1, cnt <= 0; go to IDLE.
  - `clr_req` in CLEAR is ignored; `clr_req` held high in IDLE retriggers.
  - `clr_done` is high for exactly one cycle.
- **Read-during-write to the same address:** returns the old contents unless `RDW_BYPASS_EN` is defined (see Configuration).

## Timing
- Read latency is 1 cycle: address presented at edge N, data and `rvalid` valid after edge N.
- A write takes effect at the same edge. A read issued the following cycle sees the new data.
- A clear occupies exactly DEPTH cycles of `clr_busy`=1.
  - Entry k is zeroed at the (k+1)-th edge after the edge that sampled `clr_req`.
  - `clr_done` rises together with the fall of `clr_busy`.
- A write presented in the cycle where `clr_busy` falls to 0 is still dropped, because `clr_busy` was 1 at that edge.
- `oob_err` is asserted one cycle after the offending request.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`RDW_BYPASS_EN` defined:** a port reading the address written in the same accepted cycle returns the merged value (mem & ~wmask) | (wdata & wmask).
  - The bypass does not apply to dropped writes or to the clear sequencer.
- **`RDW_BYPASS_EN` not defined:** a same-address read returns the pre-write contents.

## Test plan
- **Reset, then read:** DW=8, write 0xA5 to address 3, apply `rst`=0 for 1 cycle, read address 3 on port A -> `rdata_a`=0x00, `rvalid_a`=1 for one cycle.
- **Masked write:**
  - Write 0xFF with `wmask`=0xFF to address 10.
  - Write 0x00 with `wmask`=0x0F to address 10.
  - Read on ports A and B in the same cycle -> both return 0xF0.
- **Read-during-write:** mem[5]=0x11; write 0x22 with full mask to address 5 while `ren_a` reads address 5 -> `rdata_a`=0x11 without the macro, 0x22 with `RDW_BYPASS_EN`.
- **Clear:** DEPTH=84; fill all entries with 0xFF; pulse `clr_req`.
  - `clr_busy` is high for exactly 84 cycles.
  - A write to address 0 during the clear is dropped.
  - `clr_done` pulses once.
  - All 84 entries then read 0.
- **Out of range:** write to address 100 and read address 90 on port B -> array unchanged, `rdata_b`=0, `rvalid_b`=1, `oob_err` pulses one cycle later.
- **Reset mid-clear:** apply `rst`=0 at clear cycle 40 -> `clr_busy`=0 and `clr_done`=0 after the reset edge, all entries read 0, and a new `clr_req` restarts the clear from entry 0.

Source files
------------

// File: rtl/binreg_file_if.sv
// binreg_file_if: write, dual-read and clear-control bundle for binreg_file.
interface binreg_file_if #(parameter int DW = 1, parameter int AW = 7);
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic          ren_a;
    logic          ren_b;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          rvalid_a;
    logic          rvalid_b;
    logic          clr_req;
    logic          clr_busy;
    logic          clr_done;
    logic          oob_err;
    modport master (
        output wen, waddr, wdata, wmask, ren_a, ren_b, raddr_a, raddr_b, clr_req,
        input  rdata_a, rdata_b, rvalid_a, rvalid_b, clr_busy, clr_done, oob_err
    );
    modport slave (
        input  wen, waddr, wdata, wmask, ren_a, ren_b, raddr_a, raddr_b, clr_req,
        output rdata_a, rdata_b, rvalid_a, rvalid_b, clr_busy, clr_done, oob_err
    );
endinterface

// File: rtl/binreg_file.sv
// binreg_file: masked dual-read-port register file with background clear sequencer.
// Define RDW_BYPASS_EN to forward same-cycle write data to a same-address read.
module binreg_file #(
    parameter int DW    = 1,
    parameter int DEPTH = 84,
    parameter int AW    = 7
) (
    input logic         clk,
    input logic         rst,
    binreg_file_if.slave bus
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wcur, wnew, rd_a, rd_b;
    logic          busy, we, oob_w, oob_a, oob_b;
    assign busy         = state == CLEAR;
    assign bus.clr_busy = busy;
    assign oob_w        = bus.waddr > LAST;
    assign oob_a        = bus.raddr_a > LAST;
    assign oob_b        = bus.raddr_b > LAST;
    assign we           = bus.wen && !oob_w && !busy;
    always_comb begin
        state_nx = busy ? (cnt == LAST ? IDLE : CLEAR) : (bus.clr_req ? CLEAR : IDLE);
        cnt_nx   = (busy && cnt != LAST) ? cnt + AW'(1) : '0;
        wcur     = oob_w ? '0 : mem[bus.waddr];
        wnew     = (wcur & ~bus.wmask) | (bus.wdata & bus.wmask);
`ifdef RDW_BYPASS_EN
        rd_a     = (we && bus.waddr == bus.raddr_a) ? wnew : oob_a ? '0 : mem[bus.raddr_a];
        rd_b     = (we && bus.waddr == bus.raddr_b) ? wnew : oob_b ? '0 : mem[bus.raddr_b];
`else
        rd_a     = oob_a ? '0 : mem[bus.raddr_a];
        rd_b     = oob_b ? '0 : mem[bus.raddr_b];
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // Writes are locked out while clearing, so the two mem updates never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bus.rdata_a  <= '0;
            bus.rdata_b  <= '0;
            bus.rvalid_a <= 1'b0;
            bus.rvalid_b <= 1'b0;
            bus.clr_done <= 1'b0;
            bus.oob_err  <= 1'b0;
        end else begin
            if (we) mem[bus.waddr] <= wnew;
            if (busy) mem[cnt] <= '0;
            if (bus.ren_a) bus.rdata_a <= rd_a;
            if (bus.ren_b) bus.rdata_b <= rd_b;
            bus.rvalid_a <= bus.ren_a;
            bus.rvalid_b <= bus.ren_b;
            bus.clr_done <= busy && cnt == LAST;
            bus.oob_err  <= (bus.wen && oob_w) || (bus.ren_a && oob_a) || (bus.ren_b && oob_b);
        end
    end
endmodule

// File: tb/tb_binreg_file.sv
// tb_binreg_file: directed table, corner sequences and randomized traffic against a reference model.
module tb_binreg_file;
    localparam int DW = 8, DEPTH = 84, AW = 7;
    logic clk = 1'b0;
    logic rst = 1'b0;
    binreg_file_if #(.DW(DW), .AW(AW)) bus();
    binreg_file #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [7:0] mm [DEPTH];
    logic [7:0] ea = 0, eb = 0;
    logic eva = 0, evb = 0, eoob = 0;
    int e = 0, clr_edge = -1000000;

    typedef struct {
        logic wen; logic [6:0] waddr; logic [7:0] wdata, wmask;
        logic ren_a; logic [6:0] raddr_a; logic ren_b; logic [6:0] raddr_b;
        logic [7:0] xa, xb; logic xva, xvb, xoob;
    } vec_t;
    vec_t tbl [12];
`ifdef RDW_BYPASS_EN
    localparam logic [7:0] RDW_EXP = 8'h22;
`else
    localparam logic [7:0] RDW_EXP = 8'h11;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] peek(input logic [6:0] a);
        return a < DEPTH ? mm[a] : 8'h00;
    endfunction

    task automatic drive(input logic wen, input logic [6:0] wa, input logic [7:0] wd, input logic [7:0] wm,
                         input logic ra_en, input logic [6:0] ra, input logic rb_en, input logic [6:0] rb,
                         input logic cr);
        bus.wen = wen; bus.waddr = wa; bus.wdata = wd; bus.wmask = wm;
        bus.ren_a = ra_en; bus.raddr_a = ra; bus.ren_b = rb_en; bus.raddr_b = rb; bus.clr_req = cr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: predict from spec rules, advance, compare every output.
    task automatic tick();
        logic busy_prev, acc, r, ra_en, rb_en, oob, cr;
        logic [7:0] merged, pa, pb;
        logic [6:0] wa;
        int d;
        d = e - clr_edge;
        busy_prev = d >= 0 && d < DEPTH;
        r = rst;
        wa = bus.waddr;
        acc = bus.wen && wa < DEPTH && !busy_prev;
        merged = (peek(wa) & ~bus.wmask) | (bus.wdata & bus.wmask);
        pa = peek(bus.raddr_a);
        pb = peek(bus.raddr_b);
`ifdef RDW_BYPASS_EN
        if (acc && wa == bus.raddr_a) pa = merged;
        if (acc && wa == bus.raddr_b) pb = merged;
`endif
        ra_en = bus.ren_a;
        rb_en = bus.ren_b;
        oob = (bus.wen && wa >= DEPTH) || (ra_en && bus.raddr_a >= DEPTH) || (rb_en && bus.raddr_b >= DEPTH);
        cr = bus.clr_req;
        @(posedge clk);
        e++;
        if (!r) begin
            foreach (mm[i]) mm[i] = 0;
            ea = 0; eb = 0; eva = 0; evb = 0; eoob = 0;
            clr_edge = -1000000;
        end else begin
            if (ra_en) ea = pa;
            if (rb_en) eb = pb;
            eva = ra_en; evb = rb_en; eoob = oob;
            if (acc) mm[wa] = merged;
            d = e - clr_edge;
            if (d >= 1 && d <= DEPTH) mm[d-1] = 0;
            if (!busy_prev && cr) clr_edge = e;
        end
        #1;
        d = e - clr_edge;
        chk("rdata_a", bus.rdata_a, ea);
        chk("rdata_b", bus.rdata_b, eb);
        chk("rvalid_a", bus.rvalid_a, eva);
        chk("rvalid_b", bus.rvalid_b, evb);
        chk("oob_err", bus.oob_err, eoob);
        chk("clr_busy", bus.clr_busy, d >= 0 && d < DEPTH);
        chk("clr_done", bus.clr_done, d == DEPTH);
    endtask

    initial begin
        int busy_cnt, done_cnt;
        foreach (mm[i]) mm[i] = 0;
        tbl[0]  = '{1, 10,  8'hFF, 8'hFF, 0, 0,  0, 0,  8'h00, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 10,  8'h00, 8'h0F, 0, 0,  0, 0,  8'h00, 8'h00, 0, 0, 0};
        tbl[2]  = '{0, 0,   8'h00, 8'h00, 1, 10, 1, 10, 8'hF0, 8'hF0, 1, 1, 0};
        tbl[3]  = '{1, 5,   8'h11, 8'hFF, 0, 0,  0, 0,  8'hF0, 8'hF0, 0, 0, 0};
        tbl[4]  = '{1, 5,   8'h22, 8'hFF, 1, 5,  0, 0,  RDW_EXP, 8'hF0, 1, 0, 0};
        tbl[5]  = '{0, 0,   8'h00, 8'h00, 1, 5,  0, 0,  8'h22, 8'hF0, 1, 0, 0};
        tbl[6]  = '{1, 100, 8'hAB, 8'hFF, 0, 0,  1, 90, 8'h22, 8'h00, 0, 1, 1};
        tbl[7]  = '{0, 0,   8'h00, 8'h00, 0, 0,  0, 0,  8'h22, 8'h00, 0, 0, 0};
        tbl[8]  = '{1, 10,  8'h3C, 8'h00, 0, 0,  1, 10, 8'h22, 8'hF0, 0, 1, 0};
        tbl[9]  = '{0, 0,   8'h00, 8'h00, 1, 10, 1, 100, 8'hF0, 8'h00, 1, 1, 1};
        tbl[10] = '{1, 83,  8'h5A, 8'h3C, 0, 0,  0, 0,  8'hF0, 8'h00, 0, 0, 0};
        tbl[11] = '{0, 0,   8'h00, 8'h00, 1, 83, 1, 84, 8'h18, 8'h00, 1, 1, 1};
        idle();
        tick(); tick();
        rst = 1;
        tick();
        // reset, then read
        drive(1, 3, 8'hA5, 8'hFF, 0, 0, 0, 0, 0); tick();
        idle(); rst = 0; tick(); rst = 1;
        drive(0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
        chk("rst_read_data", bus.rdata_a, 8'h00);
        chk("rst_read_valid", bus.rvalid_a, 1'b1);
        idle(); tick();
        chk("rst_read_pulse", bus.rvalid_a, 1'b0);
        // directed table
        foreach (tbl[i]) begin
            drive(tbl[i].wen, tbl[i].waddr, tbl[i].wdata, tbl[i].wmask,
                  tbl[i].ren_a, tbl[i].raddr_a, tbl[i].ren_b, tbl[i].raddr_b, 0);
            tick();
            chk($sformatf("tbl%0d_rdata_a", i), bus.rdata_a, tbl[i].xa);
            chk($sformatf("tbl%0d_rdata_b", i), bus.rdata_b, tbl[i].xb);
            chk($sformatf("tbl%0d_rvalid_a", i), bus.rvalid_a, tbl[i].xva);
            chk($sformatf("tbl%0d_rvalid_b", i), bus.rvalid_b, tbl[i].xvb);
            chk($sformatf("tbl%0d_oob", i), bus.oob_err, tbl[i].xoob);
        end
        // full clear with writes hammered during it
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 7'(a), 8'hFF, 8'hFF, 0, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 200 && bus.clr_busy; i++) begin
            busy_cnt++;
            drive(1, 0, 8'h77, 8'hFF, 0, 0, 0, 0, 0); tick();
            done_cnt += int'(bus.clr_done);
        end
        chk("clr_busy_cycles", busy_cnt, DEPTH);
        chk("clr_done_pulses", done_cnt, 1);
        for (int a = 0; a < DEPTH; a += 2) begin
            drive(0, 0, 0, 0, 1, 7'(a), 1, 7'(a + 1), 0); tick();
            chk("clr_zero_a", bus.rdata_a, 8'h00);
            chk("clr_zero_b", bus.rdata_b, 8'h00);
        end
        // reset mid-clear, then restart from entry 0
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 7'(a), 8'hC3, 8'hFF, 0, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle();
        for (int i = 0; i < 40; i++) tick();
        rst = 0; tick(); rst = 1;
        chk("midclr_busy", bus.clr_busy, 1'b0);
        chk("midclr_done", bus.clr_done, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 1, 7'(a), 0, 0, 0); tick();
            chk("midclr_zero", bus.rdata_a, 8'h00);
        end
        for (int a = 0; a < 4; a++) begin
            drive(1, 7'(a), 8'hC3, 8'hFF, 0, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle(); tick();
        drive(0, 0, 0, 0, 1, 0, 1, 1, 0); tick();
        chk("restart_entry0", bus.rdata_a, 8'h00);
        chk("restart_entry1", bus.rdata_b, 8'hC3);
        idle();
        for (int i = 0; i < 200 && bus.clr_busy; i++) tick();
        chk("restart_finish", bus.clr_busy, 1'b0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(199) != 0;
            drive($urandom_range(1), 7'($urandom_range(95)), 8'($urandom), 8'($urandom),
                  $urandom_range(1), 7'($urandom_range(95)), $urandom_range(1), 7'($urandom_range(95)),
                  $urandom_range(60) == 0);
            tick();
        end
        rst = 1;
        idle(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
